// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter run-control sequencer.
// Latency: n/a (types only); backpressure: n/a.
package counter_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_t;

    function automatic logic is_active(input seq_state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between software-visible run-control bits and the sequencer.
// Latency: n/a (wiring only); backpressure: none, commands are level-sampled each clock.
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    import counter_sequencer_pkg::*;

    logic               start;
    logic               pause;
    logic               clear;
    logic [WIDTH-1:0]   limit;
    logic               periodic;
    logic [WIDTH-1:0]   q;
    logic               tick;
    logic               done;
    logic               busy;
    logic [STATE_W-1:0] state;

    modport master (
        output start, pause, clear, limit, periodic,
        input  q, tick, done, busy, state
    );

    modport slave (
        input  start, pause, clear, limit, periodic,
        output q, tick, done, busy, state
    );

endinterface

// File: rtl/counter_sequencer_binary_counter.sv
// Plain up-counter with synchronous clear (dominant) and count enable, wraps mod 2^WIDTH.
// Latency: 1 clock from clr/en to q; backpressure: none.
module binary_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Start/pause/clear run-control FSM driving a binary counter; one-shot or periodic wrap with tick.
// Latency: 1 clock from command to state/q change; backpressure: none, commands act every edge.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    counter_sequencer_if.slave  bus
);

    seq_state_t       st;
    logic [WIDTH-1:0] limit_r;
    logic             periodic_r;
    logic             tick_r;
    logic [WIDTH-1:0] cnt_q;
    logic             at_term;
    logic             cnt_clr;
    logic             cnt_en;
    logic             latch_start;
    logic             run_step;

    assign at_term     = (cnt_q == limit_r);
    assign latch_start = ((st == ST_IDLE) || (st == ST_DONE)) && bus.start;
    // RUN edge that is neither aborted nor paused; pause beats a coincident terminal count.
    assign run_step    = (st == ST_RUN) && !bus.clear && !bus.pause;

    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (bus.clear || latch_start) begin
            cnt_clr = 1'b1;
        end else if (run_step) begin
            cnt_clr = at_term;
            cnt_en  = !at_term;
        end
    end

    binary_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (cnt_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= ST_IDLE;
            limit_r    <= '0;
            periodic_r <= 1'b0;
            tick_r     <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (bus.clear) begin
                st <= ST_IDLE;
            end else begin
                case (st)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            st         <= ST_RUN;
                            limit_r    <= bus.limit;
                            periodic_r <= bus.periodic;
                        end
                    end
                    ST_RUN: begin
                        if (bus.pause) begin
                            st <= ST_PAUSE;
                        end else if (at_term) begin
                            tick_r <= 1'b1;
                            st     <= periodic_r ? ST_RUN : ST_DONE;
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.start) begin
                            st <= ST_RUN;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.q     = cnt_q;
    assign bus.tick  = tick_r;
    assign bus.state = st;
    assign bus.done  = (st == ST_DONE);
    assign bus.busy  = is_active(st);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed plus randomized checks of counter_sequencer against a flag-based behavioural model.
module tb_counter_sequencer;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic clk;
    logic reset;

    counter_sequencer_if #(.WIDTH(W)) bus();

    counter_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: flags describing what the sequencer is doing, plus the count.
    bit m_running, m_paused, m_finished, m_per, m_tick;
    int m_q, m_lim;

    function automatic int m_state();
        if (m_running)  return 1;
        if (m_paused)   return 2;
        if (m_finished) return 3;
        return 0;
    endfunction

    task automatic m_reset();
        m_running = 0; m_paused = 0; m_finished = 0;
        m_per = 0; m_tick = 0; m_q = 0; m_lim = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic m_edge();
        m_tick = 0;
        if (bus.clear) begin
            m_running = 0; m_paused = 0; m_finished = 0; m_q = 0;
        end else if (m_running && bus.pause) begin
            m_running = 0; m_paused = 1;
        end else if (bus.start && !m_running && !m_paused) begin
            m_running = 1; m_finished = 0;
            m_lim = int'(bus.limit); m_per = bus.periodic; m_q = 0;
        end else if (bus.start && m_paused) begin
            m_paused = 0; m_running = 1;
        end else if (m_running) begin
            if (m_q == m_lim) begin
                m_q = 0; m_tick = 1;
                if (!m_per) begin m_running = 0; m_finished = 1; end
            end else begin
                m_q = (m_q + 1) % MOD;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q"},     int'(bus.q),     m_q);
        chk({tag, ".tick"},  int'(bus.tick),  int'(m_tick));
        chk({tag, ".state"}, int'(bus.state), m_state());
        chk({tag, ".done"},  int'(bus.done),  int'(m_state() == 3));
        chk({tag, ".busy"},  int'(bus.busy),  int'(m_running || m_paused));
    endtask

    task automatic step(input string tag);
        m_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.pause = 0; bus.clear = 0;
    endtask

    int ticks;
    int guard;

    initial begin
        idle_inputs();
        bus.limit = '0; bus.periodic = 0;
        m_reset();
        reset = 0;

        // Reset phase, including an edge while reset is held.
        #2;  chk_all("rst_t2");
        #10; chk_all("rst_t12");
        #3;  reset = 1;
        for (int i = 0; i < 3; i++) step("idle_no_start");

        // One-shot, limit 5.
        bus.limit = 5; bus.periodic = 0; bus.start = 1;
        step("os5_start");
        bus.start = 0; bus.limit = 9;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step("os5_run");
            ticks += int'(bus.tick);
        end
        chk("os5_tick_count", ticks, 1);
        chk("os5_done", int'(bus.done), 1);

        // Periodic, limit 3: three ticks in 12 cycles.
        bus.limit = 3; bus.periodic = 1; bus.start = 1;
        step("per3_start");
        bus.start = 0;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step("per3_run");
            ticks += int'(bus.tick);
        end
        chk("per3_tick_count", ticks, 3);
        bus.clear = 1; step("per3_clear"); bus.clear = 0;

        // Limit 7, pause for two cycles while at the terminal count, then resume.
        bus.limit = 7; bus.periodic = 1; bus.start = 1;
        step("p7_start");
        bus.start = 0;
        guard = 0;
        while (int'(bus.q) != 7 && guard < 20) begin step("p7_run"); guard++; end
        chk("p7_reached_7", int'(bus.q), 7);
        bus.pause = 1;
        step("p7_pause1");
        step("p7_pause2");
        bus.pause = 0; bus.start = 1;
        step("p7_resume");
        bus.start = 0;
        step("p7_wrap");
        chk("p7_wrap_tick", int'(bus.tick), 1);
        step("p7_after");

        // One-shot limit 15, limit changed mid-run, clear at q=9.
        bus.clear = 1; step("c15_pre"); bus.clear = 0;
        bus.limit = 15; bus.periodic = 0; bus.start = 1;
        step("c15_start");
        bus.start = 0; bus.limit = 2;
        for (int i = 0; i < 9; i++) step("c15_run");
        chk("c15_q9", int'(bus.q), 9);
        bus.clear = 1;
        step("c15_clear");
        bus.clear = 0;
        step("c15_idle");

        // Randomized command mix.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.clear    = (r < 3);
            bus.pause    = (r >= 3 && r < 12);
            bus.start    = (r >= 12 && r < 30);
            bus.limit    = W'($urandom_range(0, MOD - 1));
            bus.periodic = 1'($urandom_range(0, 1));
            step("rand");
        end
        idle_inputs();

        // Periodic run with asynchronous reset at q=6, then limit 0 periodic.
        bus.clear = 1; step("ar_pre"); bus.clear = 0;
        bus.limit = 10; bus.periodic = 1; bus.start = 1;
        step("ar_start");
        bus.start = 0;
        for (int i = 0; i < 6; i++) step("ar_run");
        chk("ar_q6", int'(bus.q), 6);
        #3;
        reset = 0;
        m_reset();
        #1;
        chk_all("ar_async");
        #2;
        reset = 1;
        step("ar_released");
        bus.limit = 0; bus.periodic = 1; bus.start = 1;
        step("z0_start");
        bus.start = 0;
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            step("z0_run");
            ticks += int'(bus.tick);
        end
        chk("z0_tick_count", ticks, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
